// File: rtl/bsm_pkg.sv
// Shared types and helpers for the BSM operand feeder: FSM states, operand record, width clamp.
package bsm_pkg;

  localparam int BSM_DW = 32;
  localparam int W_MIN  = 2;

  typedef enum logic [1:0] {IDLE, START, STREAM} feeder_state_t;

  typedef struct packed {
    logic [BSM_DW-1:0] a;
    logic [BSM_DW-1:0] b;
    logic [4:0]        wa;
    logic [4:0]        wb;
  } bsm_operand_t;

  // The multiplier cannot handle operands narrower than W_MIN or wider than the datapath.
  function automatic logic [4:0] clamp_width(input logic [4:0] w, input logic [4:0] w_max);
    logic [4:0] r;
    r = w;
    if (w < 5'(W_MIN)) begin
      r = 5'(W_MIN);
    end else if (w > w_max) begin
      r = w_max;
    end
    return r;
  endfunction

endpackage

// File: rtl/bsm_operand_feeder_if.sv
// Operand, result and serial-multiplier signal bundle around the BSM operand feeder.
interface bsm_operand_feeder_if #(
  parameter int DW = 32,
  parameter int OW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [4:0]    in_wa;
  logic [4:0]    in_wb;

  logic          bsm_start;
  logic [4:0]    bsm_wa;
  logic [4:0]    bsm_wb;
  logic          bsm_bit_a;
  logic          bsm_bit_b;
  logic [OW-1:0] bsm_o;
  logic          bsm_done;

  logic          res_valid;
  logic [OW-1:0] res_o;
  logic          res_ready;

  logic          busy;
  logic          err_width;
  logic          err_timeout;

  // The feeder is the slave side; the surrounding system (producer, multiplier, consumer) is the master.
  modport slave (
    input  in_valid, in_a, in_b, in_wa, in_wb, bsm_o, bsm_done, res_ready,
    output in_ready, bsm_start, bsm_wa, bsm_wb, bsm_bit_a, bsm_bit_b,
           res_valid, res_o, busy, err_width, err_timeout
  );

  modport master (
    output in_valid, in_a, in_b, in_wa, in_wb, bsm_o, bsm_done, res_ready,
    input  in_ready, bsm_start, bsm_wa, bsm_wb, bsm_bit_a, bsm_bit_b,
           res_valid, res_o, busy, err_width, err_timeout
  );
endinterface

// File: rtl/bsm_bit_select.sv
// Picks serial bit idx of an operand of width w, repeating the sign bit once idx reaches w.
module bsm_bit_select
  import bsm_pkg::*;
(
  input  logic [BSM_DW-1:0] op,
  input  logic [4:0]        w,
  input  logic [4:0]        idx,
  output logic              bit_out
);

  logic [4:0] sel;

  always_comb begin
    sel     = (idx < w) ? idx : (w - 5'd1);
    bit_out = op[sel];
  end

endmodule

// File: rtl/bsm_operand_feeder.sv
// Feeds parallel operand pairs LSB-first into the bit-serial multiplier and returns its product.
module bsm_operand_feeder
  import bsm_pkg::*;
#(
  parameter int DW      = BSM_DW,
  parameter int OW      = 32,
  parameter int TIMEOUT = 128
) (
  input logic                clk,
  input logic                rst,
  bsm_operand_feeder_if.slave bus
);

  localparam int         WDW   = $clog2(TIMEOUT) + 1;
  localparam logic [4:0] W_MAX = (DW >= 31) ? 5'd31 : 5'(DW);

  feeder_state_t  state, state_n;
  bsm_operand_t   skid, cur;
  logic           skid_full;
  logic [4:0]     idx;
  logic [WDW-1:0] wdog;
  logic [OW-1:0]  res_o_q;
  logic           res_valid_q;
  logic           err_width_q;

  logic           push, pop, load_cur, capture, abort, clamp_hit;
  logic [4:0]     wa_c, wb_c;
  logic           bit_a_raw, bit_b_raw;

  // A new operation may only start if the result slot will be free when done arrives,
  // because the multiplier's done pulse cannot be held off.
  always_comb begin
    push      = bus.in_valid && !skid_full;
    pop       = res_valid_q && bus.res_ready;
    wa_c      = clamp_width(bus.in_wa, W_MAX);
    wb_c      = clamp_width(bus.in_wb, W_MAX);
    clamp_hit = (wa_c != bus.in_wa) || (wb_c != bus.in_wb);
    state_n   = state;
    load_cur  = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (skid_full && (!res_valid_q || pop)) begin
          state_n  = START;
          load_cur = 1'b1;
        end
      end
      START: state_n = STREAM;
      STREAM: begin
        if (bus.bsm_done) begin
          capture = 1'b1;
          state_n = IDLE;
        end else if (wdog == WDW'(TIMEOUT - 1)) begin
          abort   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // idx and the watchdog restart outside STREAM, so both read 0 in START and the first STREAM cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      skid        <= '0;
      skid_full   <= 1'b0;
      cur         <= '0;
      idx         <= '0;
      wdog        <= '0;
      res_o_q     <= '0;
      res_valid_q <= 1'b0;
      err_width_q <= 1'b0;
    end else begin
      state     <= state_n;
      skid_full <= (skid_full && !load_cur) || push;
      if (push) begin
        skid.a  <= BSM_DW'(bus.in_a);
        skid.b  <= BSM_DW'(bus.in_b);
        skid.wa <= wa_c;
        skid.wb <= wb_c;
        if (clamp_hit) begin
          err_width_q <= 1'b1;
        end
      end
      if (load_cur) begin
        cur <= skid;
      end
      if (state == STREAM) begin
        idx  <= (idx == 5'd31) ? idx : idx + 5'd1;
        wdog <= wdog + WDW'(1);
      end else begin
        idx  <= '0;
        wdog <= '0;
      end
      if (capture) begin
        res_o_q     <= bus.bsm_o;
        res_valid_q <= 1'b1;
      end else if (pop) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  bsm_bit_select u_sel_a (.op(cur.a), .w(cur.wa), .idx(idx), .bit_out(bit_a_raw));
  bsm_bit_select u_sel_b (.op(cur.b), .w(cur.wb), .idx(idx), .bit_out(bit_b_raw));

  assign bus.in_ready    = !skid_full;
  assign bus.bsm_start   = (state == START);
  assign bus.bsm_wa      = cur.wa;
  assign bus.bsm_wb      = cur.wb;
  assign bus.bsm_bit_a   = (state != IDLE) && bit_a_raw;
  assign bus.bsm_bit_b   = (state != IDLE) && bit_b_raw;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_o       = res_o_q;
  assign bus.busy        = (state != IDLE);
  assign bus.err_width   = err_width_q;
  assign bus.err_timeout = abort && !rst;

endmodule

// File: tb/tb_bsm_operand_feeder.sv
// Bench for bsm_operand_feeder: a behavioural serial multiplier plus a transaction scoreboard of A*B.
module tb_bsm_operand_feeder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bsm_operand_feeder_if #(.DW(32), .OW(32)) bus ();

  bsm_operand_feeder #(.DW(32), .OW(32), .TIMEOUT(128)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] res;
    int          wa;
    int          wb;
  } op_t;

  op_t         acc_q[$];
  op_t         res_q[$];
  op_t         flight;
  bit          flight_v = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          starts = 0;
  int          to_pulses = 0;
  int          start_cyc = 0;
  int          to_cyc = 0;
  int          cyc = 0;
  int          last_wa = 0;
  int          last_wb = 0;
  bit          hold_done = 1'b0;
  int          inject_req = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic longint sext(input logic [31:0] v, input int w);
    longint r = 0;
    for (int i = 0; i < w; i++) if (v[i]) r += (longint'(1) << i);
    if (v[w-1]) r -= (longint'(1) << w);
    return r;
  endfunction

  function automatic int clampw(input int w);
    return (w < 2) ? 2 : w;
  endfunction

  // Behavioural multiplier: latches widths on start, collects one bit per STREAM cycle,
  // rebuilds the signed operands and pulses done once wa+wb bits are in.
  initial begin
    bit   active = 1'b0;
    int   k = 0, n = 0, mwa = 0, mwb = 0, inject_ack = 0;
    logic abits[64];
    logic bbits[64];
    longint av, bv;
    bus.bsm_done = 1'b0;
    bus.bsm_o    = '0;
    forever begin
      @(negedge clk);
      if (bus.bsm_done) begin
        bus.bsm_done = 1'b0;
      end else if (inject_req != inject_ack) begin
        inject_ack   = inject_req;
        bus.bsm_done = 1'b1;
        bus.bsm_o    = 32'h0BAD0BAD;
      end
      if (rst) begin
        active       = 1'b0;
        bus.bsm_done = 1'b0;
      end else if (bus.bsm_start) begin
        active = 1'b1;
        k      = 0;
        mwa    = int'(bus.bsm_wa);
        mwb    = int'(bus.bsm_wb);
        n      = mwa + mwb;
      end else if (active) begin
        abits[k] = bus.bsm_bit_a;
        bbits[k] = bus.bsm_bit_b;
        if (k >= mwa) checkOutput("bit_a sign extension", bus.bsm_bit_a, abits[mwa-1]);
        if (k >= mwb) checkOutput("bit_b sign extension", bus.bsm_bit_b, bbits[mwb-1]);
        if (k == n - 1) begin
          active = 1'b0;
          if (!hold_done) begin
            av = 0;
            bv = 0;
            for (int i = 0; i < mwa; i++) if (abits[i]) av += (longint'(1) << i);
            for (int i = 0; i < mwb; i++) if (bbits[i]) bv += (longint'(1) << i);
            if (abits[mwa-1]) av -= (longint'(1) << mwa);
            if (bbits[mwb-1]) bv -= (longint'(1) << mwb);
            bus.bsm_o    = 32'(av * bv);
            bus.bsm_done = 1'b1;
          end
        end
        k++;
      end
    end
  end

  // Scoreboard: accepted ops start in order, widths hold while busy, results pop in order.
  initial begin
    op_t o;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_q.delete();
        res_q.delete();
        flight_v = 1'b0;
        continue;
      end
      checkOutput("res_valid", bus.res_valid, res_q.size() > 0);
      if (bus.bsm_start) begin
        starts++;
        start_cyc = cyc;
        last_wa   = int'(bus.bsm_wa);
        last_wb   = int'(bus.bsm_wb);
        if (acc_q.size() == 0) begin
          checkOutput("start without pending op", 1, 0);
        end else begin
          flight   = acc_q.pop_front();
          flight_v = 1'b1;
          checkOutput("bsm_wa at start", bus.bsm_wa, flight.wa);
          checkOutput("bsm_wb at start", bus.bsm_wb, flight.wb);
        end
      end else if (flight_v) begin
        checkOutput("bsm_wa held", bus.bsm_wa, flight.wa);
        checkOutput("bsm_wb held", bus.bsm_wb, flight.wb);
        if (bus.bsm_done && bus.busy) begin
          res_q.push_back(flight);
          flight_v = 1'b0;
        end
      end
      if (bus.err_timeout) begin
        to_pulses++;
        to_cyc   = cyc;
        flight_v = 1'b0;
      end
      if (bus.res_valid && bus.res_ready && res_q.size() > 0) begin
        o = res_q.pop_front();
        checkOutput("res_o vs A*B", bus.res_o, o.res);
      end
      if (bus.in_valid && bus.in_ready) begin
        o.wa  = clampw(int'(bus.in_wa));
        o.wb  = clampw(int'(bus.in_wb));
        o.res = 32'(sext(bus.in_a, o.wa) * sext(bus.in_b, o.wb));
        acc_q.push_back(o);
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] wa, input logic [4:0] wb);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_wa    = wa;
    bus.in_wb    = wb;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 500);
    if (!bus.in_ready) checkOutput("in_ready wait expired", 0, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic waitResult(output logic [31:0] r);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.res_valid && n < 400);
    if (!bus.res_valid) checkOutput("res_valid wait expired", 0, 1);
    r = bus.res_o;
    @(posedge clk);
    #1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((acc_q.size() != 0 || flight_v || res_q.size() != 0) && n < 1000);
    if (n >= 1000) checkOutput("drain wait expired", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global time limit: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    logic [31:0] r;
    int s0, p0, n;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_wa     = '0;
    bus.in_wb     = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    checkOutput("reset in_ready", bus.in_ready, 1);
    checkOutput("reset res_valid", bus.res_valid, 0);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset bsm_start", bus.bsm_start, 0);
    checkOutput("reset bsm_wa", bus.bsm_wa, 0);
    checkOutput("reset err_width", bus.err_width, 0);
    checkOutput("reset err_timeout", bus.err_timeout, 0);
    checkOutput("reset res_o", bus.res_o, 0);
    @(posedge clk);
    #1;

    $display("[TB] test 1: 15 x -7");
    bus.res_ready = 1'b1;
    s0 = starts;
    applyStimulus(32'd15, 32'hFFFFFFF9, 5'd14, 5'd15);
    waitResult(r);
    checkOutput("t1 res_o", r, 32'hFFFFFF97);
    checkOutput("t1 start count", starts - s0, 1);
    checkOutput("t1 bsm_wa", last_wa, 14);
    checkOutput("t1 bsm_wb", last_wb, 15);

    $display("[TB] test 2: 14-bit negative operand");
    applyStimulus(32'h00002FFF, 32'd2, 5'd14, 5'd15);
    waitResult(r);
    checkOutput("t2 res_o", r, 32'hFFFFDFFE);

    $display("[TB] test 3: back-to-back with result backpressure");
    bus.res_ready = 1'b0;
    s0 = starts;
    applyStimulus(32'd3, 32'd5, 5'd4, 5'd4);
    applyStimulus(32'hFFFFFFFE, 32'd3, 5'd4, 5'd3);
    waitCycles(40);
    checkOutput("t3 in_ready with skid held", bus.in_ready, 0);
    checkOutput("t3 res_valid held", bus.res_valid, 1);
    checkOutput("t3 res_o first op", bus.res_o, 32'd15);
    checkOutput("t3 idle while slot full", bus.busy, 0);
    bus.in_valid = 1'b1;
    bus.in_a     = 32'd7;
    bus.in_b     = 32'hFFFFFFFF;
    bus.in_wa    = 5'd4;
    bus.in_wb    = 5'd2;
    repeat (5) @(negedge clk);
    checkOutput("t3 third attempt stalled", bus.in_ready, 0);
    checkOutput("t3 no second start before pop", starts - s0, 1);
    @(posedge clk);
    #1 bus.res_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 300);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    waitDrain();
    checkOutput("t3 total starts", starts - s0, 3);

    $display("[TB] test 4: watchdog abort");
    hold_done = 1'b1;
    p0 = to_pulses;
    applyStimulus(32'd5, 32'd6, 5'd4, 5'd4);
    waitCycles(200);
    checkOutput("t4 timeout pulses", to_pulses - p0, 1);
    checkOutput("t4 cycles start to timeout", to_cyc - start_cyc, 128);
    checkOutput("t4 res_valid", bus.res_valid, 0);
    checkOutput("t4 busy", bus.busy, 0);
    hold_done = 1'b0;

    $display("[TB] test 5: width clamp");
    checkOutput("t5 err_width before clamp", bus.err_width, 0);
    applyStimulus(32'd7, 32'h00001234, 5'd0, 5'd31);
    waitResult(r);
    checkOutput("t5 res_o", r, 32'hFFFFEDCC);
    checkOutput("t5 bsm_wa clamped", last_wa, 2);
    checkOutput("t5 bsm_wb unclamped", last_wb, 31);
    checkOutput("t5 err_width sticky", bus.err_width, 1);

    $display("[TB] test 6: reset mid-stream");
    p0 = to_pulses;
    applyStimulus(32'd100, 32'd3, 5'd8, 5'd8);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.bsm_start && n < 50);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("t6 busy", bus.busy, 0);
    checkOutput("t6 res_valid", bus.res_valid, 0);
    checkOutput("t6 in_ready", bus.in_ready, 1);
    checkOutput("t6 bsm_start", bus.bsm_start, 0);
    checkOutput("t6 bsm_wa", bus.bsm_wa, 0);
    checkOutput("t6 bsm_wb", bus.bsm_wb, 0);
    checkOutput("t6 bit_a", bus.bsm_bit_a, 0);
    checkOutput("t6 err_width", bus.err_width, 0);
    checkOutput("t6 err_timeout", bus.err_timeout, 0);
    @(posedge clk);
    #1 inject_req++;
    waitCycles(4);
    checkOutput("t6 stray done ignored", bus.res_valid, 0);
    checkOutput("t6 no timeout pulse", to_pulses - p0, 0);
    applyStimulus(32'h00000005, 32'h0000000C, 5'd3, 5'd4);
    waitResult(r);
    checkOutput("t6 product after reset", r, 32'd12);
    waitCycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
